// File: rtl/cap_scan_controller.sv
// Round-robin capacitive pad scanner: discharge each of 9 pads, then time
// the synchronized rise of its sense line and store the count per sensor.
module cap_scan_controller #(
  parameter int DISCHARGE_CYCLES = 1000,
  parameter int TIMEOUT          = 65535
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         enable,
  input  logic [8:0]   sense_in,
  output logic [8:0]   drive_low,
  output logic [287:0] sensor_readings,
  output logic [3:0]   sensor_index,
  output logic         busy,
  output logic         scan_done
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam int DC_W  = (DISCHARGE_CYCLES > 1) ? $clog2(DISCHARGE_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, DISCHARGE, MEASURE, STORE} state_t;

  state_t                 state, state_nxt;
  logic [8:0]             sense_p0, sense_p1;
  logic [3:0]             idx;
  logic [CNT_W-1:0]       count;
  logic [DC_W-1:0]        dcnt;
  logic [8:0][31:0]       readings;
  logic                   s_cur;
  logic                   dis_last;
  logic                   count_sat;

  assign s_cur     = sense_p1[idx];
  assign dis_last  = (dcnt == DC_W'(DISCHARGE_CYCLES - 1));
  // Saturation is detected one increment early so the final count equals TIMEOUT.
  assign count_sat = (count == CNT_W'(TIMEOUT - 1));

  assign sensor_readings = readings;
  assign sensor_index    = idx;
  assign busy            = (state != IDLE);
  assign drive_low       = (state == DISCHARGE) ? 9'(9'd1 << idx) : 9'd0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (enable) state_nxt = DISCHARGE;
      DISCHARGE: if (dis_last) state_nxt = MEASURE;
      MEASURE:   if (s_cur || count_sat) state_nxt = STORE;
      STORE:     state_nxt = enable ? DISCHARGE : IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sense_p0  <= '0;
      sense_p1  <= '0;
      idx       <= '0;
      count     <= '0;
      dcnt      <= '0;
      readings  <= '0;
      scan_done <= 1'b0;
    end else begin
      // stage p0 -> p1: two-flop synchronizer on the raw pad levels
      sense_p0  <= sense_in;
      sense_p1  <= sense_p0;
      scan_done <= (state == STORE) && (idx == 4'd8);
      case (state)
        IDLE: begin
          idx  <= '0;
          dcnt <= '0;
        end
        DISCHARGE: begin
          dcnt  <= dis_last ? '0 : dcnt + 1'b1;
          count <= '0;
        end
        MEASURE: begin
          if (!s_cur) count <= count + 1'b1;
        end
        STORE: begin
          readings[idx] <= 32'(count);
          idx           <= (idx == 4'd8 || !enable) ? 4'd0 : idx + 4'd1;
          dcnt          <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/cap_scan_controller.md
CAP_SCAN_CONTROLLER -- requirements
Module: cap_scan_controller

Interface
REQ-001 The block SHALL have parameter DISCHARGE_CYCLES, default 1000, number of cycles each sensor pad is held low before a measurement.
REQ-002 The block SHALL have parameter TIMEOUT, default 65535, saturation value of a measurement count.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset: clock  input  1  system clock, all state on posedge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 enable  input  1  run continuous round-robin scanning while high.
REQ-006 sense_in  input  9  raw, asynchronous pad level per sensor; bit i = sensor i.
REQ-007 drive_low  output  9  pad discharge enable per sensor, one-hot or zero.
REQ-008 sensor_readings  output  288  slot i = bits [32i+31:32i], latest count for sensor i, zero-extended.
REQ-009 sensor_index  output  4  sensor currently being serviced, range 0..8.
REQ-010 busy  output  1  high in any state other than IDLE.
REQ-011 scan_done  output  1  one-cycle pulse when slot 8 is written.

Function
REQ-012 Each sense_in bit SHALL pass through a 2-flop synchronizer that resets to 0; s[i] denotes the second flop.
REQ-013 The FSM SHALL have states IDLE, DISCHARGE, MEASURE and STORE.
REQ-014 IDLE: idx = 0, drive_low = 0; if enable = 1, go to DISCHARGE next cycle.
REQ-015 DISCHARGE: drive_low[idx] = 1 for exactly DISCHARGE_CYCLES consecutive cycles, then go to MEASURE; all other drive_low bits are 0.
REQ-016 MEASURE: drive_low = 0; count is cleared to 0 on entry.
REQ-017 In MEASURE, count SHALL increment each cycle in which s[idx] = 0.
REQ-018 In MEASURE, the FSM SHALL go to STORE in the first cycle in which s[idx] = 1, with count unchanged.
REQ-019 In MEASURE, when count reaches TIMEOUT, count SHALL saturate at TIMEOUT and the FSM SHALL go to STORE.
REQ-020 Timing consequence of REQ-017..019: a raw rise during MEASURE cycle m (cycle 0 = first MEASURE cycle) SHALL yield a stored count of m+2.
REQ-021 STORE lasts one cycle: slot idx <= count, zero-extended to 32 bits; all other slots are unchanged in that cycle.
REQ-022 STORE, index advance: idx increments, wrapping 8 -> 0.
REQ-023 STORE, scan completion: on the wrap from 8 to 0, scan_done = 1 in the following cycle only.
REQ-024 After STORE, the FSM SHALL go to DISCHARGE if enable = 1, else to IDLE.
REQ-025 enable deasserted during DISCHARGE or MEASURE SHALL NOT abort the sensor in progress; it is finished and stored, then the FSM enters IDLE.
REQ-026 Entering IDLE SHALL reset idx to 0; readings are retained.
REQ-027 sensor_index SHALL equal idx at all times; busy SHALL equal (state != IDLE).
REQ-028 Each slot SHALL change in a single clock edge; readers never observe a partially updated 32-bit slot.
REQ-029 Sense bits other than s[idx] SHALL be ignored.

Reset
REQ-030 While reset is high, asynchronously: state = IDLE, idx = 0, count = 0, synchronizers = 0, drive_low = 0, sensor_readings = 0, busy = 0, scan_done = 0.
REQ-031 Reset asserted mid-operation SHALL take effect immediately; no store completes and drive_low releases at once.
REQ-032 After reset deasserts, the first action SHALL be IDLE evaluating enable.

Verification (DISCHARGE_CYCLES=4, TIMEOUT=20)
REQ-033 Reset release, enable=1: drive_low = 9'h001 for exactly 4 cycles, then 0; busy = 1; sensor_index = 0.
REQ-034 Raw sense_in[0] rises during MEASURE cycle 5: slot 0 = 32'd7 after STORE; sensor_index then becomes 1.
REQ-035 sense_in[3] held 0: slot 3 = 32'd20 after exactly 20 MEASURE cycles.
REQ-036 sense_in held all-ones: every slot = 0.
REQ-037 Full sweep: single scan_done pulse after slot 8 is written; next drive_low = 9'h001; no other pulses.
REQ-038 enable dropped during sensor 4 DISCHARGE: slot 4 is stored, then IDLE with sensor_index = 0 and busy = 0.
REQ-039 Reset pulsed during MEASURE of sensor 2: all slots = 0 and all outputs = 0 immediately, with no slot-2 write.
